fft_pe: RTL and testbench

Radix-2 decimation-in-frequency butterfly processing element for a 16-point fixed-point FFT datapath. Each accepted cycle it takes one complex pair (a, b) and a twiddle index. It produces the registered pair a+b and (a−b)·W16^power. An FFT controller feeds it one pair per cycle, and it sits downstream of the FIR/sample buffer.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_cmul.sv | 30 +++
 rtl/fft_pe.sv | 48 ++++
 tb/tb_fft_pe.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point radix-2 FFT datapath.
// Twiddles are W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in signed Q2.14.
package fft_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned TW_FRAC_W = 14;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned TW_COUNT = 8;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    function automatic cplx_t twiddle(input logic [2:0] k);
        cplx_t w;
        unique case (k)
            3'd0: w = '{re: 16'sd16384, im: 16'sd0};
            3'd1: w = '{re: 16'sd15137, im: -16'sd6270};
            3'd2: w = '{re: 16'sd11585, im: -16'sd11585};
            3'd3: w = '{re: 16'sd6270, im: -16'sd15137};
            3'd4: w = '{re: 16'sd0, im: -16'sd16384};
            3'd5: w = '{re: -16'sd6270, im: -16'sd15137};
            3'd6: w = '{re: -16'sd11585, im: -16'sd11585};
            default: w = '{re: -16'sd15137, im: -16'sd6270};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// Combinational complex multiply by W16^power, floor-scaled by 2^-14 and
// wrapped to 16 bits per component.
module fft_cmul
    import fft_pkg::*;
(
    input  cplx_t      d,
    input  logic [2:0] power,
    output cplx_t      p
);

    cplx_t                    w;
    logic signed [DATA_W-1:0] dr, di, wr, wi;
    logic signed [PROD_W-1:0] pr, pi, sr, si;

    always_comb begin
        w  = twiddle(power);
        dr = d.re;
        di = d.im;
        wr = w.re;
        wi = w.im;
        // |d| <= 2^15 and |w| <= 2^14, so each sum of products fits in 32 bits
        pr = dr * wr - di * wi;
        pi = dr * wi + di * wr;
        sr = pr >>> TW_FRAC_W;
        si = pi >>> TW_FRAC_W;
        p.re = sr[DATA_W-1:0];
        p.im = si[DATA_W-1:0];
    end

endmodule

// File: rtl/fft_pe.sv
// Radix-2 DIF butterfly: registers a+b and (a-b)*W16^power, one-cycle latency.
// Outputs hold while ab_valid is low; reset clears everything.
module fft_pe
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ab_valid,
    input  logic [2:0]  power,
    output logic [31:0] fft_a,
    output logic [31:0] fft_b,
    output logic        fft_pe_valid
);

    cplx_t ca, cb, sum, diff, prod;

    always_comb begin
        ca      = a;
        cb      = b;
        sum.re  = ca.re + cb.re;
        sum.im  = ca.im + cb.im;
        diff.re = ca.re - cb.re;
        diff.im = ca.im - cb.im;
    end

    fft_cmul u_cmul (
        .d     (diff),
        .power (power),
        .p     (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fft_a        <= '0;
            fft_b        <= '0;
            fft_pe_valid <= 1'b0;
        end else begin
            fft_pe_valid <= ab_valid;
            if (ab_valid) begin
                fft_a <= sum;
                fft_b <= prod;
            end
        end
    end

endmodule

// File: tb/tb_fft_pe.sv
// Self-checking bench for fft_pe: directed vectors plus random streaming
// compared against an integer-arithmetic butterfly model.
module tb_fft_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        ab_valid;
    logic [2:0]  power;
    logic [31:0] fft_a, fft_b;
    logic        fft_pe_valid;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    logic        exp_v = 1'b0;

    int wr_tab[8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
    int wi_tab[8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

    fft_pe dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .ab_valid     (ab_valid),
        .power        (power),
        .fft_a        (fft_a),
        .fft_b        (fft_b),
        .fft_pe_valid (fft_pe_valid)
    );

    always #5 clk = ~clk;

    function automatic int sx16(input logic [15:0] v);
        return int'(signed'(v));
    endfunction

    function automatic logic [15:0] lo16(input int x);
        return x[15:0];
    endfunction

    // Floor of x / 2^14 using plain integer division.
    function automatic int floor_div(input int x);
        if (x >= 0) return x / 16384;
        return -((-x + 16383) / 16384);
    endfunction

    task automatic model(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] k,
                         output logic [31:0] sa, output logic [31:0] sb);
        int ar, ai, br, bi, dr, di, pr, pi;
        ar = sx16(va[31:16]);
        ai = sx16(va[15:0]);
        br = sx16(vb[31:16]);
        bi = sx16(vb[15:0]);
        dr = sx16(lo16(ar - br));
        di = sx16(lo16(ai - bi));
        pr = dr * wr_tab[k] - di * wi_tab[k];
        pi = dr * wi_tab[k] + di * wr_tab[k];
        sa = {lo16(ar + br), lo16(ai + bi)};
        sb = {lo16(floor_div(pr)), lo16(floor_div(pi))};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, update the expected state, and check all outputs after the edge.
    task automatic step(input string tag, input logic vr, input logic vv,
                        input logic [31:0] va, input logic [31:0] vb, input logic [2:0] k);
        logic [31:0] sa, sb;
        @(negedge clk);
        rst = vr;
        ab_valid = vv;
        a = va;
        b = vb;
        power = k;
        @(posedge clk);
        #1;
        if (vr) begin
            exp_a = '0;
            exp_b = '0;
            exp_v = 1'b0;
        end else begin
            exp_v = vv;
            if (vv) begin
                model(va, vb, k, sa, sb);
                exp_a = sa;
                exp_b = sb;
            end
        end
        chk({tag, "_valid"}, {31'b0, fft_pe_valid}, {31'b0, exp_v});
        chk({tag, "_a"}, fft_a, exp_a);
        chk({tag, "_b"}, fft_b, exp_b);
    endtask

    initial begin
        rst = 1'b1;
        ab_valid = 1'b0;
        a = '0;
        b = '0;
        power = '0;

        step("rst0", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        step("rst1", 1'b1, 1'b1, 32'h1234_5678, 32'h0000_1111, 3'd3);
        chk("rst_a_zero", fft_a, 32'h0);

        step("k0", 1'b0, 1'b1, 32'h0100_0000, 32'h0080_0000, 3'd0);
        chk("k0_a_const", fft_a, 32'h0180_0000);
        chk("k0_b_const", fft_b, 32'h0080_0000);

        step("k4", 1'b0, 1'b1, 32'h0100_0000, 32'h0080_0000, 3'd4);
        chk("k4_b_const", fft_b, 32'h0000_FF80);

        step("k2", 1'b0, 1'b1, 32'h0100_0000, 32'h0000_0000, 3'd2);
        chk("k2_a_const", fft_a, 32'h0100_0000);
        chk("k2_b_const", fft_b, 32'h00B5_FF4A);

        step("wrap", 1'b0, 1'b1, 32'h7FFF_0000, 32'h0001_0000, 3'd0);
        chk("wrap_a_const", fft_a, 32'h8000_0000);
        chk("wrap_b_const", fft_b, 32'h7FFE_0000);

        for (int i = 0; i < 8; i++) begin
            step("stream", 1'b0, 1'b1, $urandom, $urandom, 3'(i));
        end

        // Invalid inputs during the gap must not disturb the held outputs.
        step("gap", 1'b0, 1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 3'd5);
        step("resume", 1'b0, 1'b1, $urandom, $urandom, 3'd7);
        step("resume2", 1'b0, 1'b1, $urandom, $urandom, 3'd1);

        step("rst_mid", 1'b1, 1'b1, $urandom, $urandom, 3'd6);
        step("post_rst", 1'b0, 1'b1, $urandom, $urandom, 3'd3);

        for (int i = 0; i < 40; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
